// File: rtl/uart_frame_sender.sv
// Frame builder in front of the UART byte transmitter: wraps N buffer bytes as
// HDR0 HDR1 N[15:8] N[7:0] payload CHK, one byte per transmitter handshake.
module uart_frame_sender #(
    parameter int          ADDR_W = 10,
    parameter logic [7:0]  HDR0   = 8'hAA,
    parameter logic [7:0]  HDR1   = 8'h55
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic [15:0]       Length,
    output logic              Rd_En,
    output logic [ADDR_W-1:0] Rd_Addr,
    input  logic [7:0]        Rd_Data,
    output logic              Byte_En,
    output logic [7:0]        Data_Byte,
    input  logic              Tx_Done,
    output logic              Busy,
    output logic              Frame_Done
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_FETCH      = 3'd1,
        S_FETCH_WAIT = 3'd2,
        S_SEND       = 3'd3,
        S_WAIT_DONE  = 3'd4
    } state_t;

    state_t              state_q;
    logic [15:0]         len_q;
    logic [16:0]         pos_q;        // frame position of the byte currently in flight
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          chk_q;
    logic [7:0]          data_q;
    logic                byte_en_q;
    logic                rd_en_q;
    logic                busy_q;
    logic                frame_done_q;

    logic [16:0]         next_pos_d;
    logic [16:0]         last_pos_d;
    logic                is_last_d;
    logic                is_payload_d;
    logic [7:0]          ctrl_byte_d;
    logic [7:0]          chk_add_d;

    // Classify the byte that follows the one in flight and prepare its value.
    always_comb begin
        next_pos_d   = pos_q + 17'd1;
        last_pos_d   = {1'b0, len_q} + 17'd4;
        is_last_d    = (pos_q == last_pos_d);
        is_payload_d = (next_pos_d >= 17'd4) && (next_pos_d < last_pos_d);
        case (next_pos_d)
            17'd1:   ctrl_byte_d = HDR1;
            17'd2:   ctrl_byte_d = len_q[15:8];
            17'd3:   ctrl_byte_d = len_q[7:0];
            default: ctrl_byte_d = chk_q;
        endcase
        if ((next_pos_d == 17'd2) || (next_pos_d == 17'd3)) begin
            chk_add_d = ctrl_byte_d;
        end else begin
            chk_add_d = 8'h00;
        end
    end

    // Frame sequencer; Data_Byte only changes after the matching Tx_Done.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q      <= S_IDLE;
            len_q        <= 16'h0000;
            pos_q        <= 17'd0;
            addr_q       <= {ADDR_W{1'b0}};
            chk_q        <= 8'h00;
            data_q       <= 8'h00;
            byte_en_q    <= 1'b0;
            rd_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        len_q     <= Length;
                        pos_q     <= 17'd0;
                        addr_q    <= {ADDR_W{1'b0}};
                        chk_q     <= 8'h00;
                        data_q    <= HDR0;
                        byte_en_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= S_SEND;
                    end
                end
                S_SEND: begin
                    byte_en_q <= 1'b0;
                    state_q   <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (Tx_Done) begin
                        if (is_last_d) begin
                            busy_q       <= 1'b0;
                            frame_done_q <= 1'b1;
                            state_q      <= S_IDLE;
                        end else if (is_payload_d) begin
                            rd_en_q <= 1'b1;
                            pos_q   <= next_pos_d;
                            state_q <= S_FETCH;
                        end else begin
                            data_q    <= ctrl_byte_d;
                            chk_q     <= chk_q + chk_add_d;
                            byte_en_q <= 1'b1;
                            pos_q     <= next_pos_d;
                            state_q   <= S_SEND;
                        end
                    end
                end
                S_FETCH: begin
                    rd_en_q <= 1'b0;
                    state_q <= S_FETCH_WAIT;
                end
                S_FETCH_WAIT: begin
                    data_q    <= Rd_Data;
                    chk_q     <= chk_q + Rd_Data;
                    addr_q    <= addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    byte_en_q <= 1'b1;
                    state_q   <= S_SEND;
                end
                default: begin
                    state_q   <= S_IDLE;
                    byte_en_q <= 1'b0;
                    rd_en_q   <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign Rd_En      = rd_en_q;
    assign Rd_Addr    = addr_q;
    assign Byte_En    = byte_en_q;
    assign Data_Byte  = data_q;
    assign Busy       = busy_q;
    assign Frame_Done = frame_done_q;

endmodule
